rv32_mod_stall_ctrl: RTL and testbench
======================================

Name: rv32_mod_stall_ctrl

Overview:
- Parametrised issue/stall controller for the rv32imc single-stage core.
- Decides per cycle whether PC, RF, CSR and IF may mutate.
- Generalises LSU-only stalling to NUM_UNITS multi-cycle units (e.g. 0=LSU, 1=MULDIV, 2=CSR-slow), each driven through a start/valid handshake.
- Adds a per-stall timeout watchdog with a sticky fault state, plus an IF flush on taken branches.

Parameters:
- NUM_UNITS, 3: number of multi-cycle units; legal range 1..8.
- TIMEOUT_W, 8: width of the stall timeout counter.
- TIMEOUT_CYCLES, 255: number of wait cycles before a fault; must be at least 1 and at most 2^TIMEOUT_W-1.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- reset_n  in  1  synchronous reset, active-low.
- is_instr_new  in  1  decoded instruction valid this cycle.
- unit_sel  in  NUM_UNITS  instruction needs unit i; lowest set bit wins; all-zero means single-cycle.
- unit_valid  in  NUM_UNITS  unit i result ready.
- is_branch_taken  in  1  current committing instruction redirects PC.
- unit_start  out  NUM_UNITS  one-cycle, one-hot start pulse to a unit.
- enable_mut_pc  out  1  PC update enable.
- enable_mut_rf  out  1  register file write enable.
- enable_mut_csr  out  1  CSR/retire-counter update enable.
- enable_mut_if  out  1  IF fetch enable; registered.
- flush_if  out  1  registered; discard in-flight fetch.
- stalled  out  1  FSM in S_WAIT.
- timeout_err  out  1  sticky fault flag.
- stall_cycles  out  32  perf counter (see Optional Feature).

Behaviour:
- FSM states: S_RUN, S_WAIT, S_FAULT. On reset the state is S_RUN.
- Reset values: while reset_n=0 at a clock edge, the FSM goes to S_RUN and the pending register and timeout counter clear. enable_mut_if<=1, flush_if<=0, timeout_err<=0, stall_cycles<=0.
- Reset gating: combinational outputs (pc/rf/csr enables, unit_start) are forced to 0 whenever reset_n=0, regardless of state.
- "Commit" means enable_mut_pc, enable_mut_rf and enable_mut_csr are all 1 for that cycle, with if_next=1.
- S_RUN, is_instr_new=1 and unit_sel=0: commit in the same cycle; zero added latency.
- S_RUN, is_instr_new=1 and unit_sel!=0:
  - unit_start = the lowest set bit of unit_sel, pulsed for one cycle.
  - The same one-hot value is latched into pending; the timeout counter clears.
  - No enables are asserted; next state is S_WAIT.
  - unit_valid in this same cycle is ignored.
- S_RUN, is_instr_new=0: all enables 0, if_next=0, state held.
- S_WAIT, (unit_valid & pending)!=0: commit, then go to S_RUN. Minimum latency from issue to commit is 1 cycle.
- S_WAIT, otherwise:
  - All enables are 0 and unit_start is 0; is_instr_new is ignored.
  - The counter increments.
  - When the counter reaches TIMEOUT_CYCLES-1 while still waiting: go to S_FAULT and set timeout_err<=1.
  - Completion takes priority over timeout when both happen in the same cycle.
- unit_valid from non-pending units is ignored in every state.
- S_FAULT: all enables 0, if_next=0, unit_start=0. Exit only via reset; timeout_err stays 1.
- Registered IF signals:
  - enable_mut_if <= if_next every cycle; this gives a 1-cycle delay after reset and breaks the IF/ID/controller combinational loop.
  - flush_if <= (commit & is_branch_taken). is_branch_taken outside a commit cycle is ignored.
- stalled = (state==S_WAIT).

Optional Feature:
- Macro: RV32_STALL_PERF_EN.
- When defined: stall_cycles increments by 1 (wrapping at 2^32) on every cycle with state S_WAIT, or with S_RUN and is_instr_new=0. It clears on reset.
- When undefined: stall_cycles is tied to 32'd0 and no counter flops are built.

Test Plan:
- Reset release: hold reset_n=0 for 3 cycles, then release with is_instr_new=0 -> enable_mut_if=1 in the first cycle after release, then 0; all other outputs 0.
- Single-cycle op: is_instr_new=1, unit_sel=3'b000 -> pc/rf/csr enables=1 in the same cycle; enable_mut_if=1 on the next cycle; no unit_start.
- Multi-unit priority: unit_sel=3'b110 -> unit_start=3'b010 for exactly 1 cycle; stalled=1. Assert unit_valid=3'b100 then 3'b010 four cycles later -> commit only on the 3'b010 cycle; then stalled=0.
- Timeout: TIMEOUT_CYCLES=4, issue to unit 0, never return valid -> timeout_err=1 after 4 S_WAIT cycles. Later is_instr_new/unit_valid activity -> no enables until reset_n=0.
- Branch flush: LSU completion with is_branch_taken=1 -> flush_if=1 the next cycle for one cycle. is_branch_taken=1 during S_WAIT without valid -> flush_if stays 0.
- Perf (RV32_STALL_PERF_EN): 1 idle cycle plus an LSU stall of 5 wait cycles -> stall_cycles=6. With the macro undefined -> stall_cycles=0.

Source files
------------

// File: rtl/rv32_mod_stall_ctrl.sv
// Issue/stall controller for the rv32imc single-stage core: gates PC/RF/CSR/IF mutation
// around NUM_UNITS multi-cycle units, with a stall watchdog. Optional perf counter: RV32_STALL_PERF_EN.
module rv32_mod_stall_ctrl #(
    parameter int unsigned NUM_UNITS      = 3,
    parameter int unsigned TIMEOUT_W      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 is_instr_new,
    input  logic [NUM_UNITS-1:0] unit_sel,
    input  logic [NUM_UNITS-1:0] unit_valid,
    input  logic                 is_branch_taken,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic                 enable_mut_pc,
    output logic                 enable_mut_rf,
    output logic                 enable_mut_csr,
    output logic                 enable_mut_if,
    output logic                 flush_if,
    output logic                 stalled,
    output logic                 timeout_err,
    output logic [31:0]          stall_cycles
);

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [NUM_UNITS-1:0] pending, pending_next;
    logic [NUM_UNITS-1:0] sel_lowest;
    logic [TIMEOUT_W-1:0] tmo_cnt, tmo_cnt_next;
    logic                 commit;
    logic                 fault_set;

    // Next-state and issue/commit decode; lowest set bit of unit_sel wins.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        tmo_cnt_next = tmo_cnt;
        commit       = 1'b0;
        fault_set    = 1'b0;
        unit_start   = '0;
        sel_lowest   = unit_sel & (~unit_sel + NUM_UNITS'(1));

        case (state)
            S_RUN: begin
                if (is_instr_new) begin
                    if (unit_sel == '0) begin
                        commit = 1'b1;
                    end else begin
                        unit_start   = sel_lowest;
                        pending_next = sel_lowest;
                        tmo_cnt_next = '0;
                        state_next   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Completion wins over a watchdog expiry in the same cycle.
                if ((unit_valid & pending) != '0) begin
                    commit     = 1'b1;
                    state_next = S_RUN;
                end else if (tmo_cnt == TMO_LAST) begin
                    fault_set  = 1'b1;
                    state_next = S_FAULT;
                end else begin
                    tmo_cnt_next = tmo_cnt + TIMEOUT_W'(1);
                end
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_RUN;
            end
        endcase

        if (!reset_n) begin
            commit     = 1'b0;
            unit_start = '0;
        end

        enable_mut_pc  = commit;
        enable_mut_rf  = commit;
        enable_mut_csr = commit;
    end

    // IF enable is registered to break the IF/ID/controller combinational loop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_RUN;
            pending       <= '0;
            tmo_cnt       <= '0;
            enable_mut_if <= 1'b1;
            flush_if      <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= state_next;
            pending       <= pending_next;
            tmo_cnt       <= tmo_cnt_next;
            enable_mut_if <= commit;
            flush_if      <= commit & is_branch_taken;
            if (fault_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign stalled = (state == S_WAIT);

`ifdef RV32_STALL_PERF_EN
    logic [31:0] perf_cnt;

    // Counts cycles lost to stalls or to an empty decode slot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_cnt <= 32'd0;
        end else if ((state == S_WAIT) || ((state == S_RUN) && !is_instr_new)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign stall_cycles = perf_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_rv32_mod_stall_ctrl.sv
// Bench for rv32_mod_stall_ctrl: vector table through a scoreboard queue, plus
// hand sequences for watchdog, completion-vs-timeout and the perf counter.
module tb_rv32_mod_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       is_instr_new;
    logic [2:0] unit_sel;
    logic [2:0] unit_valid;
    logic       is_branch_taken;

    logic [2:0]  unit_start, to_unit_start;
    logic        en_pc, en_rf, en_csr, en_if, flush_if, stalled, timeout_err;
    logic        to_en_pc, to_en_rf, to_en_csr, to_en_if, to_flush_if, to_stalled, to_timeout_err;
    logic [31:0] stall_cycles, to_stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv32_mod_stall_ctrl #(.NUM_UNITS(3), .TIMEOUT_W(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .is_instr_new(is_instr_new), .unit_sel(unit_sel),
        .unit_valid(unit_valid), .is_branch_taken(is_branch_taken), .unit_start(unit_start),
        .enable_mut_pc(en_pc), .enable_mut_rf(en_rf), .enable_mut_csr(en_csr),
        .enable_mut_if(en_if), .flush_if(flush_if), .stalled(stalled),
        .timeout_err(timeout_err), .stall_cycles(stall_cycles)
    );

    rv32_mod_stall_ctrl #(.NUM_UNITS(3), .TIMEOUT_W(8), .TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset_n(reset_n), .is_instr_new(is_instr_new), .unit_sel(unit_sel),
        .unit_valid(unit_valid), .is_branch_taken(is_branch_taken), .unit_start(to_unit_start),
        .enable_mut_pc(to_en_pc), .enable_mut_rf(to_en_rf), .enable_mut_csr(to_en_csr),
        .enable_mut_if(to_en_if), .flush_if(to_flush_if), .stalled(to_stalled),
        .timeout_err(to_timeout_err), .stall_cycles(to_stall_cycles)
    );

    typedef struct {
        logic       rst_n;
        logic       ins;
        logic [2:0] sel;
        logic [2:0] vld;
        logic       br;
        logic [2:0] start;
        logic       en;
        logic       ifen;
        logic       flush;
        logic       stl;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs away from the rising edge, then let comb logic settle.
    task automatic apply(input logic r, input logic ins, input logic [2:0] sel,
                         input logic [2:0] vld, input logic br);
        @(negedge clk);
        reset_n         = r;
        is_instr_new    = ins;
        unit_sel        = sel;
        unit_valid      = vld;
        is_branch_taken = br;
        #1;
    endtask

    initial begin
        vec_t e;
        logic [31:0] perf_exp;

        //                 rst ins sel     vld     br  start   en  if  fl  stl err
        vecs.push_back(vec_t'{0, 0, 3'b000, 3'b000, 0, 3'b000, 0, 1, 0, 0, 0});
        vecs.push_back(vec_t'{0, 1, 3'b001, 3'b001, 1, 3'b000, 0, 1, 0, 0, 0});
        vecs.push_back(vec_t'{0, 1, 3'b000, 3'b000, 0, 3'b000, 0, 1, 0, 0, 0});
        vecs.push_back(vec_t'{1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 1, 0, 0, 0});
        vecs.push_back(vec_t'{1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 3'b000, 3'b000, 0, 3'b000, 1, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 3'b000, 3'b000, 1, 3'b000, 1, 1, 0, 0, 0});
        vecs.push_back(vec_t'{1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 1, 1, 0, 0});
        vecs.push_back(vec_t'{1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0});
        // Multi-unit priority: 110 issues to unit 1; unit 2's valid is ignored.
        vecs.push_back(vec_t'{1, 1, 3'b110, 3'b010, 0, 3'b010, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 3'b000, 3'b100, 0, 3'b000, 0, 0, 0, 1, 0});
        vecs.push_back(vec_t'{1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 1, 0});
        vecs.push_back(vec_t'{1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 1, 0});
        vecs.push_back(vec_t'{1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 1, 0});
        vecs.push_back(vec_t'{1, 0, 3'b000, 3'b010, 0, 3'b000, 1, 0, 0, 1, 0});
        vecs.push_back(vec_t'{1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 1, 0, 0, 0});
        // Branch flush around an LSU op; valid at issue is ignored.
        vecs.push_back(vec_t'{1, 1, 3'b001, 3'b001, 1, 3'b001, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 3'b000, 3'b000, 1, 3'b000, 0, 0, 0, 1, 0});
        vecs.push_back(vec_t'{1, 0, 3'b000, 3'b001, 1, 3'b000, 1, 0, 0, 1, 0});
        vecs.push_back(vec_t'{1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 1, 1, 0, 0});
        vecs.push_back(vec_t'{1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0});

        apply(0, 0, 3'b000, 3'b000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst_n, vecs[i].ins, vecs[i].sel, vecs[i].vld, vecs[i].br);
            exp_q.push_back(vecs[i]);
            if (exp_q.size() == 0) begin
                chk($sformatf("scoreboard_empty[%0d]", i), 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("unit_start[%0d]", i), 32'(unit_start), 32'(e.start));
                chk($sformatf("en_pc[%0d]", i),      32'(en_pc),      32'(e.en));
                chk($sformatf("en_rf[%0d]", i),      32'(en_rf),      32'(e.en));
                chk($sformatf("en_csr[%0d]", i),     32'(en_csr),     32'(e.en));
                chk($sformatf("en_if[%0d]", i),      32'(en_if),      32'(e.ifen));
                chk($sformatf("flush_if[%0d]", i),   32'(flush_if),   32'(e.flush));
                chk($sformatf("stalled[%0d]", i),    32'(stalled),    32'(e.stl));
                chk($sformatf("timeout_err[%0d]", i), 32'(timeout_err), 32'(e.err));
`ifndef RV32_STALL_PERF_EN
                chk($sformatf("stall_cycles[%0d]", i), stall_cycles, 32'd0);
`endif
            end
        end

        // Watchdog (limit 4): fault after four empty wait cycles, then sticky.
        apply(0, 0, 3'b000, 3'b000, 0);
        apply(0, 0, 3'b000, 3'b000, 0);
        apply(1, 1, 3'b001, 3'b000, 0);
        chk("to_issue_start", 32'(to_unit_start), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            apply(1, 0, 3'b000, 3'b000, 0);
            chk($sformatf("to_wait_stalled[%0d]", k), 32'(to_stalled), 32'd1);
            chk($sformatf("to_wait_err[%0d]", k), 32'(to_timeout_err), 32'd0);
        end
        apply(1, 1, 3'b000, 3'b001, 0);
        chk("to_fault_err",     32'(to_timeout_err), 32'd1);
        chk("to_fault_stalled", 32'(to_stalled),     32'd0);
        chk("to_fault_en_pc",   32'(to_en_pc),       32'd0);
        apply(1, 1, 3'b001, 3'b001, 1);
        chk("to_fault_start",   32'(to_unit_start),  32'd0);
        chk("to_fault_en_rf",   32'(to_en_rf),       32'd0);
        chk("to_fault_en_if",   32'(to_en_if),       32'd0);
        chk("to_fault_sticky",  32'(to_timeout_err), 32'd1);
        apply(0, 1, 3'b000, 3'b000, 0);
        apply(1, 0, 3'b000, 3'b000, 0);
        chk("to_reset_clears_err", 32'(to_timeout_err), 32'd0);
        chk("to_reset_en_if",      32'(to_en_if),       32'd1);

        // Completion on the last allowed wait cycle beats the watchdog.
        apply(1, 1, 3'b001, 3'b000, 0);
        for (int k = 1; k <= 3; k++) begin
            apply(1, 0, 3'b000, 3'b000, 0);
        end
        apply(1, 0, 3'b000, 3'b001, 0);
        chk("to_edge_commit", 32'(to_en_csr), 32'd1);
        apply(1, 0, 3'b000, 3'b000, 0);
        chk("to_edge_err",     32'(to_timeout_err), 32'd0);
        chk("to_edge_stalled", 32'(to_stalled),     32'd0);
        chk("to_edge_en_if",   32'(to_en_if),       32'd1);

        // Perf: one idle cycle plus a five-cycle LSU stall.
        apply(0, 0, 3'b000, 3'b000, 0);
        apply(1, 0, 3'b000, 3'b000, 0);
        apply(1, 1, 3'b001, 3'b000, 0);
        for (int k = 1; k <= 4; k++) begin
            apply(1, 0, 3'b000, 3'b000, 0);
        end
        apply(1, 0, 3'b000, 3'b001, 0);
        chk("perf_commit", 32'(en_pc), 32'd1);
        apply(1, 1, 3'b000, 3'b000, 0);
`ifdef RV32_STALL_PERF_EN
        perf_exp = 32'd6;
`else
        perf_exp = 32'd0;
`endif
        chk("perf_stall_cycles", stall_cycles, perf_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
